// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
// Produces the {remainder, quotient} word written into HI/LO after WIDTH
// iterations. Only one divide is in flight at a time. A pipeline flush
// (annul) abandons the divide in flight.
//
// Signed divides run on operand magnitudes. The signs are fixed up at the
// end: the quotient truncates toward zero, and the remainder takes the sign
// of the dividend.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   start       in   divide request, held by the caller until ready is seen
//   signed_div  in   1 = DIV (two's complement), 0 = DIVU; sampled with start
//   annul       in   flush; drops the divide in flight (no ready pulse)
//   a           in   dividend, sampled in IDLE with start
//   b           in   divisor, sampled in IDLE with start
//   div_res     out  registered {remainder, quotient}; holds until next result
//   ready       out  registered one-cycle pulse while div_res is fresh
//   div_zero    out  registered; high with ready when the divisor was zero
//   stall       out  combinational start & ~ready, for the hazard unit
// -----------------------------------------------------------------------------
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_div,
   input  logic                 annul,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   div_res,
   output logic                 ready,
   output logic                 div_zero,
   output logic                 stall
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DZERO,
      S_ON,
      S_END
   } state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     rem_q, rem_d;     // partial remainder
   logic [WIDTH-1:0]     quo_q, quo_d;     // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0]     dvs_q, dvs_d;     // divisor magnitude
   logic                 q_neg_q, q_neg_d;
   logic                 r_neg_q, r_neg_d;
   logic [2*WIDTH-1:0]   res_q, res_d;
   logic                 ready_q, ready_d;
   logic                 dz_q, dz_d;

   // Operand magnitudes, which are used only for signed divides
   logic [WIDTH-1:0]     a_mag, b_mag;

   assign a_mag = (signed_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
   assign b_mag = (signed_div && b[WIDTH-1]) ? (~b + 1'b1) : b;

   // One restoring step. The shifted remainder needs one extra bit because
   // it can reach 2*divisor-1. The top bit of the trial difference is the
   // borrow: when it is set, the subtraction went negative and the shifted
   // value is kept as the new remainder.
   logic [WIDTH:0]       r_shift, r_trial;
   logic [WIDTH-1:0]     rem_step, quo_step;

   assign r_shift  = {rem_q, quo_q[WIDTH-1]};
   assign r_trial  = r_shift - {1'b0, dvs_q};
   assign rem_step = r_trial[WIDTH] ? r_shift[WIDTH-1:0] : r_trial[WIDTH-1:0];
   assign quo_step = {quo_q[WIDTH-2:0], ~r_trial[WIDTH]};

   // Sign fix-up applied to the result of the last iteration
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   assign quo_fix = q_neg_q ? (~quo_step + 1'b1) : quo_step;
   assign rem_fix = r_neg_q ? (~rem_step + 1'b1) : rem_step;

   // NOTE: every signal written here is given a default first. Without the
   // defaults, a branch that skips an assignment would infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      res_d   = res_q;
      ready_d = 1'b0;
      dz_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !annul) begin
               if (b == '0) begin
                  state_d = S_DZERO;
               end else begin
                  dvs_d   = b_mag;
                  quo_d   = a_mag;
                  rem_d   = '0;
                  cnt_d   = '0;
                  q_neg_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_neg_d = signed_div & a[WIDTH-1];
                  state_d = S_ON;
               end
            end
         end

         S_ON: begin
            if (annul) begin
               state_d = S_IDLE;
            end else begin
               rem_d = rem_step;
               quo_d = quo_step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  res_d   = {rem_fix, quo_fix};
                  ready_d = 1'b1;
                  state_d = S_END;
               end
            end
         end

         S_DZERO: begin
            if (annul) begin
               state_d = S_IDLE;
            end else begin
               res_d   = '0;
               ready_d = 1'b1;
               dz_d    = 1'b1;
               state_d = S_END;
            end
         end

         // The result is already committed here, so annul is ignored
         S_END: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments. Every flop then
   // samples its pre-edge value, whatever order the blocks run in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         res_q   <= '0;
         ready_q <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         res_q   <= res_d;
         ready_q <= ready_d;
         dz_q    <= dz_d;
      end
   end

   assign div_res  = res_q;
   assign ready    = ready_q;
   assign div_zero = dz_q;
   assign stall    = start & ~ready_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Self-checking bench for div_unit. Expected results come from plain 64-bit
// integer division of the operands, not from the shift/subtract algorithm.
// The bench covers the directed test-plan cases, a randomized sweep, annul,
// and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_div_unit;

   logic          clk;
   logic          rst;
   logic          start;
   logic          signed_div;
   logic          annul;
   logic [31:0]   a;
   logic [31:0]   b;
   logic [63:0]   div_res;
   logic          ready;
   logic          div_zero;
   logic          stall;

   int            n_vec;
   int            n_err;
   logic [63:0]   last_res;

   div_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .signed_div (signed_div),
      .annul      (annul),
      .a          (a),
      .b          (b),
      .div_res    (div_res),
      .ready      (ready),
      .div_zero   (div_zero),
      .stall      (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: integer division on 64-bit values. With 64 bits the
   // 0x80000000 / -1 case cannot overflow.
   function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                           input logic sgn);
      longint sx, sy, q, r;
      if (y == 32'd0) return 64'd0;
      if (sgn) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
      end else begin
         sx = longint'({32'd0, x});
         sy = longint'({32'd0, y});
      end
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
   endfunction

   // One full handshake. The task must be called just after a falling edge,
   // with the DUT in IDLE. It returns just after a falling edge, with the DUT
   // back in IDLE.
   task automatic do_div(input logic [31:0] x, input logic [31:0] y, input logic sgn);
      logic [63:0] exp;
      int          cyc;
      int          exp_lat;
      int          bad_stall;
      bit          seen;
      exp     = ref_div(x, y, sgn);
      exp_lat = (y == 32'd0) ? 2 : 33;
      a          = x;
      b          = y;
      signed_div = sgn;
      start      = 1'b1;
      @(posedge clk);                 // start sampled at this edge (E0)
      #1;
      a          = $urandom;          // later operand changes must be ignored
      b          = $urandom;
      signed_div = 1'($urandom_range(0, 1));
      cyc        = 0;
      seen       = 1'b0;
      bad_stall  = 0;
      while (!seen && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (ready) seen = 1'b1;
         else if (stall !== 1'b1) bad_stall++;
      end
      check("ready_seen", 64'(seen), 64'd1);
      check("latency", 64'(cyc), 64'(exp_lat));
      check("stall_hi", 64'(bad_stall), 64'd0);
      check("stall_lo", 64'(stall), 64'd0);
      check("div_res", div_res, exp);
      check("div_zero", 64'(div_zero), 64'(y == 32'd0));
      start = 1'b0;
      @(negedge clk);
      check("ready_pulse", 64'(ready), 64'd0);
      check("res_hold", div_res, exp);
      last_res = exp;
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      int          kind;
      bit          rdy_hit;

      n_vec      = 0;
      n_err      = 0;
      last_res   = 64'd0;
      rst        = 1'b1;
      start      = 1'b0;
      signed_div = 1'b0;
      annul      = 1'b0;
      a          = 32'd0;
      b          = 32'd0;
      #2 rst = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_res", div_res, 64'd0);
      check("rst_ready", 64'(ready), 64'd0);
      check("rst_dz", 64'(div_zero), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Directed test-plan cases
      do_div(32'd100, 32'd7, 1'b0);
      check("plan_100_7", last_res, 64'h00000002_0000000E);
      do_div(32'hFFFFFFF9, 32'd2, 1'b1);
      do_div(32'd7, 32'hFFFFFFFE, 1'b1);
      do_div(32'hFFFFFFFF, 32'd1, 1'b0);
      do_div(32'h80000000, 32'hFFFFFFFF, 1'b1);
      do_div(32'd1234, 32'd0, 1'b1);
      do_div(32'hFFFFFFF9, 32'd2, 1'b0);

      // Annul while in IDLE blocks the start. The latency check in the next
      // divide shows that no divide began earlier.
      annul = 1'b1;
      start = 1'b1;
      a     = 32'd50;
      b     = 32'd5;
      rdy_hit = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (ready) rdy_hit = 1'b1;
      end
      check("annul_idle_rdy", 64'(rdy_hit), 64'd0);
      annul = 1'b0;
      start = 1'b0;
      do_div(32'd50, 32'd5, 1'b0);

      // Annul at iteration 10: no ready pulse, div_res unchanged, and a new
      // 9/3 starts the cycle after the return to IDLE.
      a          = 32'hDEADBEEF;
      b          = 32'd13;
      signed_div = 1'b0;
      start      = 1'b1;
      rdy_hit    = 1'b0;
      @(posedge clk);
      repeat (10) begin
         @(posedge clk);
         #1 if (ready) rdy_hit = 1'b1;
      end
      @(negedge clk);
      annul = 1'b1;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (ready) rdy_hit = 1'b1;
      annul = 1'b0;
      check("annul_no_rdy", 64'(rdy_hit), 64'd0);
      check("annul_res_keep", div_res, last_res);
      do_div(32'd9, 32'd3, 1'b0);
      check("plan_9_3", last_res, 64'h00000000_00000003);

      // Reset at iteration 5: outputs clear at once
      a          = 32'd77777;
      b          = 32'd3;
      signed_div = 1'b0;
      start      = 1'b1;
      @(posedge clk);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      #1;
      check("mid_rst_res", div_res, 64'd0);
      check("mid_rst_ready", 64'(ready), 64'd0);
      check("mid_rst_dz", 64'(div_zero), 64'd0);
      check("mid_rst_stall", 64'(stall), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Randomized sweep, biased toward the corner cases
      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 7));
         ra   = $urandom;
         rb   = $urandom;
         rs   = 1'($urandom_range(0, 1));
         case (kind)
            0: rb = 32'd0;
            1: rb = 32'hFFFFFFFF;
            2: rb = 32'($urandom_range(1, 15));
            3: ra = 32'h80000000;
            default: ;
         endcase
         do_div(ra, rb, rs);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
